// File: rtl/arm_controller_if.sv
// Control/status bundle between the single-cycle ARM datapath and its control unit.
// The master side is the datapath, which supplies the instruction bits and ALU flags.
interface arm_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [1:0]  ALUControl;
    logic        MemWrite;
    logic        MemtoReg;
    logic        PCSrc;
    logic [3:0]  Flags;

    modport master (
        output Instr, ALUFlags,
        input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
        input  MemWrite, MemtoReg, PCSrc, Flags
    );

    modport slave (
        input  Instr, ALUFlags,
        output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
        output MemWrite, MemtoReg, PCSrc, Flags
    );
endinterface

// File: rtl/arm_controller.sv
// Single-cycle ARM control unit: main/ALU decode, NZCV flag register and condition
// evaluation that gates register, memory and PC side effects.
module arm_controller (
    input  logic            clk,
    input  logic            reset,
    arm_controller_if.slave ctl
);
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;

    assign cond  = ctl.Instr[19:16];
    assign op    = ctl.Instr[15:14];
    assign funct = ctl.Instr[13:8];
    assign rd    = ctl.Instr[3:0];

    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_w_dec;
    logic       mem_w;
    logic       branch;
    logic       alu_op;

    always_comb begin
        reg_src    = 2'b00;
        imm_src    = 2'b00;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_w_dec  = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        case (op)
            2'b00: begin
                reg_w_dec = 1'b1;
                alu_op    = 1'b1;
                alu_src   = funct[5];
            end
            2'b01: begin
                imm_src = 2'b01;
                alu_src = 1'b1;
                if (funct[0]) begin
                    mem_to_reg = 1'b1;
                    reg_w_dec  = 1'b1;
                end else begin
                    reg_src = 2'b10;
                    mem_w   = 1'b1;
                end
            end
            2'b10: begin
                reg_src = 2'b01;
                imm_src = 2'b10;
                alu_src = 1'b1;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic       cmd_ok;

    // Only ADD/SUB may touch C,V; logical ops update N,Z alone.
    always_comb begin
        alu_control = 2'b00;
        flag_w      = 2'b00;
        cmd_ok      = 1'b1;
        if (alu_op) begin
            case (funct[4:1])
                4'b0100: begin alu_control = 2'b00; flag_w = {funct[0], funct[0]}; end
                4'b0010: begin alu_control = 2'b01; flag_w = {funct[0], funct[0]}; end
                4'b0000: begin alu_control = 2'b10; flag_w = {funct[0], 1'b0};     end
                4'b1100: begin alu_control = 2'b11; flag_w = {funct[0], 1'b0};     end
                default: cmd_ok = 1'b0;
            endcase
        end
    end

    logic reg_w;
    logic pcs;

    assign reg_w = reg_w_dec & cmd_ok;
    assign pcs   = branch | ((rd == 4'hF) & reg_w);

    logic [3:0] flags_reg;
    logic [3:0] flags_next;
    logic       n_flag, z_flag, c_flag, v_flag;
    logic       cond_ex;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_reg;

    // Condition looks only at the stored flags, never at this instruction's ALU result.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_flag;
            4'b0001: cond_ex = ~z_flag;
            4'b0010: cond_ex = c_flag;
            4'b0011: cond_ex = ~c_flag;
            4'b0100: cond_ex = n_flag;
            4'b0101: cond_ex = ~n_flag;
            4'b0110: cond_ex = v_flag;
            4'b0111: cond_ex = ~v_flag;
            4'b1000: cond_ex = c_flag & ~z_flag;
            4'b1001: cond_ex = ~c_flag | z_flag;
            4'b1010: cond_ex = (n_flag == v_flag);
            4'b1011: cond_ex = (n_flag != v_flag);
            4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_ex = z_flag | (n_flag != v_flag);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Slice 1 holds {N,Z}, slice 0 holds {C,V}; each has its own write enable.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_pair
            assign flags_next[gi*2 +: 2] = (flag_w[gi] & cond_ex) ? ctl.ALUFlags[gi*2 +: 2]
                                                                  : flags_reg[gi*2 +: 2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg <= 4'b0000;
        end else begin
            flags_reg <= flags_next;
        end
    end

    assign ctl.RegSrc     = reg_src;
    assign ctl.ImmSrc     = imm_src;
    assign ctl.ALUSrc     = alu_src;
    assign ctl.ALUControl = alu_control;
    assign ctl.MemtoReg   = mem_to_reg;
    assign ctl.RegWrite   = reg_w & cond_ex & ~reset;
    assign ctl.MemWrite   = mem_w & cond_ex & ~reset;
    assign ctl.PCSrc      = pcs & cond_ex & ~reset;
    assign ctl.Flags      = flags_reg;
endmodule

// File: tb/tb_arm_controller.sv
// Directed bench for arm_controller: decode, condition gating and flag register behaviour.
module tb_arm_controller;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    arm_controller_if bus ();

    arm_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one instruction and let the combinational decode settle, well before the next edge.
    task automatic apply(input logic [31:0] ins, input logic [3:0] af);
        bus.Instr    = ins[31:12];
        bus.ALUFlags = af;
        #2;
        $display("step instr=%08h aluflags=%04b rst=%0b flags=%04b", ins, af, reset, bus.Flags);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Condition written as base test per cond[3:1] with cond[0] inverting it.
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic base;
        case (c[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] & ~f[2];
            3'd5: base = ~(f[3] ^ f[0]);
            3'd6: base = ~f[2] & ~(f[3] ^ f[0]);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? ~base : base;
    endfunction

    initial begin
        logic [31:0] ins;
        errors = 0;
        checks = 0;
        bus.Instr    = '0;
        bus.ALUFlags = '0;

        // Reset with a flag-setting ADDS in flight: side effects suppressed, flags cleared.
        reset = 1'b1;
        apply(32'hE0921003, 4'b1111);
        check("rst_regwrite", bus.RegWrite, 0);
        check("rst_memwrite", bus.MemWrite, 0);
        check("rst_pcsrc", bus.PCSrc, 0);
        check("rst_alucontrol", bus.ALUControl, 2'b00);
        tick();
        check("rst_flags", bus.Flags, 4'b0000);
        reset = 1'b0;

        // ADDS R1,R2,R3 producing Z
        apply(32'hE0921003, 4'b0100);
        check("adds_regwrite", bus.RegWrite, 1);
        check("adds_alucontrol", bus.ALUControl, 2'b00);
        check("adds_alusrc", bus.ALUSrc, 0);
        check("adds_pcsrc", bus.PCSrc, 0);
        check("adds_flags_before", bus.Flags, 4'b0000);
        tick();
        check("adds_flags", bus.Flags, 4'b0100);

        // BEQ taken
        apply(32'h0A000002, 4'b0000);
        check("beq_pcsrc", bus.PCSrc, 1);
        check("beq_immsrc", bus.ImmSrc, 2'b10);
        check("beq_regsrc", bus.RegSrc, 2'b01);
        check("beq_regwrite", bus.RegWrite, 0);
        tick();
        check("beq_flags_hold", bus.Flags, 4'b0100);

        // SUBS R0,R0,#1 producing C
        apply(32'hE2500001, 4'b0010);
        check("subs_alusrc", bus.ALUSrc, 1);
        check("subs_alucontrol", bus.ALUControl, 2'b01);
        check("subs_regwrite", bus.RegWrite, 1);
        tick();
        check("subs_flags", bus.Flags, 4'b0010);

        // BEQ not taken; live ALUFlags show Z but only stored flags count
        apply(32'h0A000002, 4'b0100);
        check("beq_nt_pcsrc", bus.PCSrc, 0);
        tick();
        apply(32'h1A000002, 4'b0000);
        check("bne_pcsrc", bus.PCSrc, 1);
        tick();

        // Memory operations
        apply(32'hE5921004, 4'b0000);
        check("ldr_regwrite", bus.RegWrite, 1);
        check("ldr_memtoreg", bus.MemtoReg, 1);
        check("ldr_immsrc", bus.ImmSrc, 2'b01);
        check("ldr_memwrite", bus.MemWrite, 0);
        check("ldr_alusrc", bus.ALUSrc, 1);
        tick();
        apply(32'hE5821004, 4'b0000);
        check("str_memwrite", bus.MemWrite, 1);
        check("str_regsrc", bus.RegSrc, 2'b10);
        check("str_regwrite", bus.RegWrite, 0);
        check("str_memtoreg", bus.MemtoReg, 0);
        tick();
        apply(32'h05821004, 4'b0000);
        check("streq_memwrite", bus.MemWrite, 0);
        tick();

        // ADD PC,R0,R2 (no S): redirect, flags untouched
        apply(32'hE080F002, 4'b1111);
        check("addpc_pcsrc", bus.PCSrc, 1);
        check("addpc_regwrite", bus.RegWrite, 1);
        tick();
        check("addpc_flags_hold", bus.Flags, 4'b0010);

        // ANDS: N,Z from ALU, C,V kept
        apply(32'hE0121003, 4'b1011);
        check("ands_alucontrol", bus.ALUControl, 2'b10);
        tick();
        check("ands_flags", bus.Flags, 4'b1010);

        // Unsupported cmd 0001 with S
        apply(32'hE0321003, 4'b0101);
        check("eors_regwrite", bus.RegWrite, 0);
        check("eors_alucontrol", bus.ALUControl, 2'b00);
        tick();
        check("eors_flags_hold", bus.Flags, 4'b1010);

        // Op=11: everything zero
        apply(32'hEC000000, 4'b1111);
        check("op11_regsrc", bus.RegSrc, 0);
        check("op11_regwrite", bus.RegWrite, 0);
        check("op11_immsrc", bus.ImmSrc, 0);
        check("op11_alusrc", bus.ALUSrc, 0);
        check("op11_alucontrol", bus.ALUControl, 0);
        check("op11_memwrite", bus.MemWrite, 0);
        check("op11_memtoreg", bus.MemtoReg, 0);
        check("op11_pcsrc", bus.PCSrc, 0);
        tick();
        check("op11_flags_hold", bus.Flags, 4'b1010);

        // Cond=1111 never executes
        apply(32'hF0821003, 4'b0000);
        check("nv_regwrite", bus.RegWrite, 0);
        tick();

        // Condition sweep: preload every flag value, then try all 16 conditions on ADD
        for (int f = 0; f < 16; f++) begin
            apply(32'hE0921003, f[3:0]);
            tick();
            check("sweep_preload", bus.Flags, f[3:0]);
            for (int c = 0; c < 16; c++) begin
                ins = {c[3:0], 28'h0821003};
                apply(ins, ~f[3:0]);
                check($sformatf("sweep_f%0h_c%0h", f, c), bus.RegWrite, cond_ref(c[3:0], f[3:0]));
            end
        end

        // Reset wins over a simultaneous flag write
        reset = 1'b1;
        apply(32'hE0921003, 4'b0110);
        check("rst2_regwrite", bus.RegWrite, 0);
        tick();
        check("rst2_flags", bus.Flags, 4'b0000);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
